mem_ctrl_top: RTL and testbench

Parametrised single-port memory subsystem with a request/acknowledge handshake, programmable wait states generated from an internal clock-enable divider, per-byte write enables and address range checking. It sits between the CPU load/store path and on-chip word RAM. The whole block runs on the system clock; slowed access timing comes from tick counting, never from a derived clock.

---
 rtl/mem_ctrl_top.sv | 165 ++++++++++++++++
 tb/tb_mem_ctrl_top.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_top.sv
// mem_ctrl_top: single-port word RAM behind a req/ack handshake with
// tick-based wait states, byte enables and an address range check.
// Ports: clk, rst_n (async, active low); req/we/addr/wdata/be sampled in
// IDLE; busy, ack (1-cycle), rdata/err valid with ack and held after.
// Optional MEM_CTRL_PARITY_EN adds par_inject (in) and parity_err (out)
// with one stored even-parity bit per word.
module mem_ctrl_top #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256,
    parameter int DIV    = 4,
    parameter int WAIT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [0:ADDR_W-1]     addr,
    input  logic [0:DATA_W-1]     wdata,
    input  logic [0:DATA_W/8-1]   be,
    output logic                  busy,
    output logic                  ack,
    output logic [0:DATA_W-1]     rdata,
    output logic                  err
`ifdef MEM_CTRL_PARITY_EN
    ,
    input  logic                  par_inject,
    output logic                  parity_err
`endif
);

    localparam int NB = DATA_W / 8;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t              state_q;
    logic                we_q;
    // Internal copies are descending: MSB-first port lane 0 lands on
    // the top byte, so be_q[j] guards wd_q[8*j +: 8].
    logic [ADDR_W-1:0]   a_q;
    logic [DATA_W-1:0]   wd_q;
    logic [NB-1:0]       be_q;
    logic [DW-1:0]       div_q;
    logic [TW-1:0]       tick_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   merged;
    logic [AW-1:0]       idx;
    logic                in_range;
    logic                mem_we;

    assign idx      = a_q[AW-1:0];
    assign in_range = {1'b0, a_q} < LIMIT;
    assign mem_we   = (state_q == S_ACCESS) && we_q && in_range;
    assign rdata    = rdata_q;

    always_comb begin
        merged = mem[idx];
        for (int j = 0; j < NB; j++) begin
            if (be_q[j]) merged[8*j +: 8] = wd_q[8*j +: 8];
        end
    end

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= merged;
    end

`ifdef MEM_CTRL_PARITY_EN
    logic par_mem [DEPTH];
    logic pinj_q;

    always_ff @(posedge clk) begin
        if (mem_we) par_mem[idx] <= (^merged) ^ pinj_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            a_q     <= '0;
            wd_q    <= '0;
            be_q    <= '0;
            div_q   <= '0;
            tick_q  <= '0;
`ifdef MEM_CTRL_PARITY_EN
            pinj_q     <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        a_q     <= addr;
                        wd_q    <= wdata;
                        be_q    <= be;
                        div_q   <= '0;
                        tick_q  <= '0;
                        busy    <= 1'b1;
`ifdef MEM_CTRL_PARITY_EN
                        pinj_q  <= par_inject;
`endif
                        state_q <= (WAIT > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (div_q == DW'(DIV - 1)) begin
                        div_q  <= '0;
                        tick_q <= tick_q + 1'b1;
                        if (tick_q == TW'(WAIT - 1)) state_q <= S_ACCESS;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_ACCESS: begin
                    state_q <= S_DONE;
                    ack     <= 1'b1;
                    if (!in_range) begin
                        rdata_q <= '0;
                        err     <= 1'b1;
`ifdef MEM_CTRL_PARITY_EN
                        parity_err <= 1'b0;
`endif
                    end else if (we_q) begin
                        rdata_q <= merged;
                        err     <= 1'b0;
`ifdef MEM_CTRL_PARITY_EN
                        parity_err <= 1'b0;
`endif
                    end else begin
                        rdata_q <= mem[idx];
                        err     <= 1'b0;
`ifdef MEM_CTRL_PARITY_EN
                        parity_err <= par_mem[idx] != (^mem[idx]);
`endif
                    end
                end
                S_DONE: begin
                    ack     <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl_top.sv
// tb_mem_ctrl_top: randomized self-checking bench for mem_ctrl_top.
// Three instances: defaults, WAIT=0/DIV=1, WAIT=3/DIV=2.
module tb_mem_ctrl_top;

    localparam int ND = 3;
    localparam int W_P [ND] = '{1, 0, 3};
    localparam int D_P [ND] = '{4, 1, 2};

    logic        clk = 1'b0;
    logic        rst_n [ND];
    logic        req   [ND];
    logic        we    [ND];
    logic [0:31] addr  [ND];
    logic [0:31] wdata [ND];
    logic [0:3]  be    [ND];
    logic        busy  [ND];
    logic        ack   [ND];
    logic [0:31] rdata [ND];
    logic        err   [ND];
`ifdef MEM_CTRL_PARITY_EN
    logic        par_inject [ND];
    logic        parity_err [ND];
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mref [ND][256];
    logic        pref [ND][256];

    always #5 clk = ~clk;

    mem_ctrl_top u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .we(we[0]),
        .addr(addr[0]), .wdata(wdata[0]), .be(be[0]),
        .busy(busy[0]), .ack(ack[0]), .rdata(rdata[0]), .err(err[0])
`ifdef MEM_CTRL_PARITY_EN
        , .par_inject(par_inject[0]), .parity_err(parity_err[0])
`endif
    );

    mem_ctrl_top #(.WAIT(0), .DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .we(we[1]),
        .addr(addr[1]), .wdata(wdata[1]), .be(be[1]),
        .busy(busy[1]), .ack(ack[1]), .rdata(rdata[1]), .err(err[1])
`ifdef MEM_CTRL_PARITY_EN
        , .par_inject(par_inject[1]), .parity_err(parity_err[1])
`endif
    );

    mem_ctrl_top #(.WAIT(3), .DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n[2]), .req(req[2]), .we(we[2]),
        .addr(addr[2]), .wdata(wdata[2]), .be(be[2]),
        .busy(busy[2]), .ack(ack[2]), .rdata(rdata[2]), .err(err[2])
`ifdef MEM_CTRL_PARITY_EN
        , .par_inject(par_inject[2]), .parity_err(parity_err[2])
`endif
    );

    // Reference: byte lane i (be bit i, MSB-first) is the i-th most
    // significant byte of the word.
    task automatic model(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b,
                         input logic pi, output logic [31:0] xr,
                         output logic xe, output logic xp);
        logic [31:0] m;
        if (a >= 256) begin
            xr = 0; xe = 1; xp = 0;
        end else if (w) begin
            m = mref[d][a];
            for (int i = 0; i < 4; i++)
                if (b[3-i]) m[31-8*i -: 8] = wd[31-8*i -: 8];
            mref[d][a] = m;
            pref[d][a] = (^m) ^ pi;
            xr = m; xe = 0; xp = 0;
        end else begin
            xr = mref[d][a]; xe = 0;
            xp = pref[d][a] != (^mref[d][a]);
        end
    endtask

    // Drives one transaction; lat is edges from acceptance to ack, -1 on timeout.
    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b,
                        input logic pi, output logic [31:0] rd,
                        output logic e, output logic pe, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (busy[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        req[d] = 1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
`ifdef MEM_CTRL_PARITY_EN
        par_inject[d] = pi;
`endif
        @(posedge clk);
        #1 req[d] = 0;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (ack[d]) begin
                lat = i;
                break;
            end
        end
        rd = rdata[d];
        e = err[d];
        pe = 0;
`ifdef MEM_CTRL_PARITY_EN
        pe = parity_err[d];
`endif
        if (pi) pe = pe;
    endtask

    task automatic test_reset();
        int acks;
        for (int d = 0; d < ND; d++) begin
            rst_n[d] = 0; req[d] = 0; we[d] = 0;
            addr[d] = 0; wdata[d] = 0; be[d] = 0;
`ifdef MEM_CTRL_PARITY_EN
            par_inject[d] = 0;
`endif
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (busy[d] !== 1'b0 || ack[d] !== 1'b0 ||
                rdata[d] !== 32'h0 || err[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_vals dut%0d busy=%b ack=%b rdata=%h err=%b want 0",
                         d, busy[d], ack[d], rdata[d], err[d]);
            end
`ifdef MEM_CTRL_PARITY_EN
            checks++;
            if (parity_err[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_perr dut%0d got %b want 0", d, parity_err[d]);
            end
`endif
        end
        @(negedge clk);
        for (int d = 0; d < ND; d++) rst_n[d] = 1;
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < ND; d++) if (ack[d] !== 1'b0) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL idle_ack got %0d acks want 0", acks);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd, xr;
        logic e, pe, xe, xp;
        int lat;
        model(0, 1, 5, 32'hDEADBEEF, 4'b1111, 0, xr, xe, xp);
        xfer(0, 1, 5, 32'hDEADBEEF, 4'b1111, 0, rd, e, pe, lat);
        checks++;
        if (lat != W_P[0] * D_P[0] + 1 || rd !== xr || e !== 1'b0) begin
            errors++;
            $display("FAIL wr_full lat=%0d rd=%h err=%b want lat=5 rd=%h err=0",
                     lat, rd, e, xr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ack[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL ack_pulse ack=%b busy=%b want 0 0", ack[0], busy[0]);
        end
        model(0, 0, 5, 0, 0, 0, xr, xe, xp);
        xfer(0, 0, 5, 0, 0, 0, rd, e, pe, lat);
        checks++;
        if (lat != 5 || rd !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL rd_full lat=%0d rd=%h err=%b want 5 deadbeef 0", lat, rd, e);
        end
    endtask

    task automatic test_partial();
        logic [31:0] rd, xr;
        logic e, pe, xe, xp;
        int lat;
        model(0, 1, 5, 32'h11223344, 4'b0101, 0, xr, xe, xp);
        xfer(0, 1, 5, 32'h11223344, 4'b0101, 0, rd, e, pe, lat);
        checks++;
        if (rd !== xr || e !== 1'b0) begin
            errors++;
            $display("FAIL partial_wr rd=%h err=%b want %h 0", rd, e, xr);
        end
        model(0, 0, 5, 0, 0, 0, xr, xe, xp);
        xfer(0, 0, 5, 0, 0, 0, rd, e, pe, lat);
        checks++;
        if (rd !== 32'hDE22BE44 || e !== 1'b0) begin
            errors++;
            $display("FAIL partial_rd rd=%h err=%b want de22be44 0", rd, e);
        end
        model(0, 1, 5, 32'hFFFFFFFF, 4'b0000, 0, xr, xe, xp);
        xfer(0, 1, 5, 32'hFFFFFFFF, 4'b0000, 0, rd, e, pe, lat);
        xfer(0, 0, 5, 0, 4'b1111, 0, rd, e, pe, lat);
        checks++;
        if (lat != 5 || rd !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL be_zero lat=%0d rd=%h want 5 de22be44", lat, rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, xr;
        logic e, pe, xe, xp;
        int lat;
        model(0, 1, 255, 32'hCAFEF00D, 4'b1111, 0, xr, xe, xp);
        xfer(0, 1, 255, 32'hCAFEF00D, 4'b1111, 0, rd, e, pe, lat);
        model(0, 1, 256, 32'h12345678, 4'b1111, 0, xr, xe, xp);
        xfer(0, 1, 256, 32'h12345678, 4'b1111, 0, rd, e, pe, lat);
        checks++;
        if (lat != 5 || rd !== xr || e !== xe) begin
            errors++;
            $display("FAIL oor_wr lat=%0d rd=%h err=%b want 5 %h %b", lat, rd, e, xr, xe);
        end
        xfer(0, 0, 256, 0, 4'b1111, 0, rd, e, pe, lat);
        checks++;
        if (rd !== 32'h0 || e !== 1'b1) begin
            errors++;
            $display("FAIL oor_rd rd=%h err=%b want 0 1", rd, e);
        end
        model(0, 0, 255, 0, 0, 0, xr, xe, xp);
        xfer(0, 0, 255, 0, 4'b1111, 0, rd, e, pe, lat);
        checks++;
        if (rd !== 32'hCAFEF00D || e !== 1'b0) begin
            errors++;
            $display("FAIL edge_rd rd=%h err=%b want cafef00d 0", rd, e);
        end
    endtask

    task automatic test_latency();
        logic [31:0] rd, xr;
        logic e, pe, xe, xp;
        int lat;
        for (int d = 1; d < ND; d++) begin
            model(d, 1, 3, 32'hA5A5_0000 + d, 4'b1111, 0, xr, xe, xp);
            xfer(d, 1, 3, 32'hA5A5_0000 + d, 4'b1111, 0, rd, e, pe, lat);
            checks++;
            if (lat != ((d == 1) ? 1 : 7)) begin
                errors++;
                $display("FAIL latency dut%0d got %0d want %0d", d, lat, (d == 1) ? 1 : 7);
            end
            xfer(d, 0, 3, 0, 0, 0, rd, e, pe, lat);
            checks++;
            if (rd !== xr || lat != W_P[d] * D_P[d] + 1) begin
                errors++;
                $display("FAIL lat_rd dut%0d rd=%h lat=%0d want %h %0d",
                         d, rd, lat, xr, W_P[d] * D_P[d] + 1);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, xr;
        logic e, pe, xe, xp;
        int lat, acks;
        model(2, 1, 9, 32'h0BADF00D, 4'b1111, 0, xr, xe, xp);
        xfer(2, 1, 9, 32'h0BADF00D, 4'b1111, 0, rd, e, pe, lat);
        repeat (2) @(negedge clk);
        req[2] = 1; we[2] = 1; addr[2] = 9; wdata[2] = 32'hFFFFFFFF; be[2] = 4'b1111;
        @(posedge clk);
        #1 req[2] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n[2] = 0;
        #1;
        checks++;
        if (busy[2] !== 1'b0 || ack[2] !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset busy=%b ack=%b want 0 0", busy[2], ack[2]);
        end
        @(negedge clk);
        rst_n[2] = 1;
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (ack[2]) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL abort_ack got %0d acks want 0", acks);
        end
        xfer(2, 0, 9, 0, 0, 0, rd, e, pe, lat);
        checks++;
        if (rd !== 32'h0BADF00D || lat != 7) begin
            errors++;
            $display("FAIL abort_rd rd=%h lat=%0d want 0badf00d 7", rd, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, xr, v;
        logic e, pe, xe, xp;
        int lat;
        for (int k = 0; k < 4; k++) begin
            v = $urandom;
            model(1, 1, 20 + k, v, 4'b1111, 0, xr, xe, xp);
            xfer(1, 1, 20 + k, v, 4'b1111, 0, rd, e, pe, lat);
            xfer(1, 0, 20 + k, 0, 0, 0, rd, e, pe, lat);
            checks++;
            if (rd !== v || e !== 1'b0) begin
                errors++;
                $display("FAIL raw addr=%0d rd=%h err=%b want %h 0", 20 + k, rd, e, v);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, xr, a, v;
        logic [3:0] b;
        logic w, e, pe, xe, xp;
        int lat;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 12; i++) begin
                v = $urandom;
                model(d, 1, 32 + i, v, 4'b1111, 0, xr, xe, xp);
                xfer(d, 1, 32 + i, v, 4'b1111, 0, rd, e, pe, lat);
            end
            for (int i = 0; i < 40; i++) begin
                w = 1'($urandom_range(0, 1));
                a = ($urandom_range(0, 7) == 0) ? 32'(256 + $urandom_range(0, 3))
                                                : 32'(32 + $urandom_range(0, 11));
                v = $urandom;
                b = 4'($urandom_range(0, 15));
                model(d, w, a, v, b, 0, xr, xe, xp);
                xfer(d, w, a, v, b, 0, rd, e, pe, lat);
                checks++;
                if (rd !== xr || e !== xe || pe !== xp ||
                    lat != W_P[d] * D_P[d] + 1) begin
                    errors++;
                    $display("FAIL rand dut%0d we=%b a=%0d be=%b rd=%h e=%b pe=%b lat=%0d want %h %b %b %0d",
                             d, w, a, b, rd, e, pe, lat, xr, xe, xp, W_P[d] * D_P[d] + 1);
                end
            end
        end
    endtask

`ifdef MEM_CTRL_PARITY_EN
    task automatic test_parity();
        logic [31:0] rd, xr;
        logic e, pe, xe, xp;
        int lat;
        model(0, 1, 7, 32'h13572468, 4'b1111, 1, xr, xe, xp);
        xfer(0, 1, 7, 32'h13572468, 4'b1111, 1, rd, e, pe, lat);
        checks++;
        if (pe !== 1'b0) begin
            errors++;
            $display("FAIL par_wr got %b want 0", pe);
        end
        xfer(0, 0, 7, 0, 0, 0, rd, e, pe, lat);
        checks++;
        if (pe !== 1'b1 || rd !== 32'h13572468) begin
            errors++;
            $display("FAIL par_inj pe=%b rd=%h want 1 13572468", pe, rd);
        end
        model(0, 1, 7, 32'h13572468, 4'b1111, 0, xr, xe, xp);
        xfer(0, 1, 7, 32'h13572468, 4'b1111, 0, rd, e, pe, lat);
        xfer(0, 0, 7, 0, 0, 0, rd, e, pe, lat);
        checks++;
        if (pe !== 1'b0) begin
            errors++;
            $display("FAIL par_clean got %b want 0", pe);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_partial();
        test_out_of_range();
        test_latency();
        test_abort();
        test_back_to_back();
        test_random();
`ifdef MEM_CTRL_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
